sram_arbiter: RTL and testbench

Shares the single 256K×16 asynchronous SRAM between two requesters: the note-instruction fetch engine (port F, read-only) and the song loader (port L, read/write). Each port uses a req/ack handshake. The block generates all SRAM strobes, address and write-data drive through a fixed four-phase access sequence. It replaces direct SRAM pin driving by the CPU so that songs can be loaded while the player runs.

---
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 256Kx16 asynchronous SRAM between the note-fetch
// engine (port F, read-only) and the song loader (port L, read/write).
// Every access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE, with all
// SRAM strobes, address and write data driven from registers so the pins
// never glitch. ACCESS_CYCLES must lie in 1..15.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    // fetch port (read-only)
    input  logic        F_REQ,
    input  logic [17:0] F_ADDR,
    output logic        F_ACK,
    output logic [15:0] F_RDATA,
    // loader port (read/write)
    input  logic        L_REQ,
    input  logic        L_WE,
    input  logic [17:0] L_ADDR,
    input  logic [15:0] L_WDATA,
    output logic        L_ACK,
    output logic [15:0] L_RDATA,
    // SRAM pins (strobes active-low)
    output logic        SRAM_CE,
    output logic        SRAM_OE,
    output logic        SRAM_WE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_D
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_L = 1'b1
    } port_t;

    // The down-counter starts at ACCESS_CYCLES-1 so ACCESS lasts exactly
    // ACCESS_CYCLES cycles, leaving on the cycle the counter reads zero.
    localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    port_t      last_grant;   // port of the current/most recent grant
    logic       cur_we;       // latched write flag of the current access
    logic [3:0] cnt;          // remaining ACCESS cycles minus one

    port_t       pick;
    logic [17:0] pick_addr;
    logic        pick_we;

    // Round-robin choice: a lone requester wins, on contention the port not
    // granted last wins.
    always_comb begin
        // NOTE: every variable of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        pick      = PORT_F;
        pick_addr = F_ADDR;
        pick_we   = 1'b0;
        if (L_REQ && (!F_REQ || last_grant == PORT_F)) begin
            pick      = PORT_L;
            pick_addr = L_ADDR;
            pick_we   = L_WE;
        end
    end

    // Access sequencer with registered SRAM strobes, acknowledges and read data.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            last_grant  <= PORT_L;
            cur_we      <= 1'b0;
            cnt         <= 4'd0;
            SRAM_CE     <= 1'b1;
            SRAM_OE     <= 1'b1;
            SRAM_WE     <= 1'b1;
            SRAM_LB     <= 1'b1;
            SRAM_UB     <= 1'b1;
            SRAM_A      <= 18'd0;
            SRAM_DQ_OUT <= 16'd0;
            SRAM_DQ_OE  <= 1'b0;
            F_ACK       <= 1'b0;
            L_ACK       <= 1'b0;
            F_RDATA     <= 16'd0;
            L_RDATA     <= 16'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side reads the value from before this clock edge.
            F_ACK <= 1'b0;
            L_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (F_REQ || L_REQ) begin
                        last_grant <= pick;
                        cur_we     <= pick_we;
                        SRAM_A     <= pick_addr;
                        if (pick_we) begin
                            SRAM_DQ_OUT <= L_WDATA;
                        end
                        SRAM_CE    <= 1'b0;
                        SRAM_LB    <= 1'b0;
                        SRAM_UB    <= 1'b0;
                        SRAM_OE    <= pick_we;   // reads enable the output now
                        SRAM_WE    <= 1'b1;
                        SRAM_DQ_OE <= pick_we;   // writes drive data a cycle before WE
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    cnt     <= ACCESS_LOAD;
                    SRAM_WE <= ~cur_we;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (cnt == 4'd0) begin
                        SRAM_OE <= 1'b1;
                        SRAM_WE <= 1'b1;
                        if (last_grant == PORT_L) begin
                            L_ACK <= 1'b1;
                            if (!cur_we) begin
                                L_RDATA <= SRAM_D;
                            end
                        end else begin
                            F_ACK   <= 1'b1;
                            F_RDATA <= SRAM_D;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    // Write data stayed on the bus through DONE for hold time.
                    SRAM_CE    <= 1'b1;
                    SRAM_LB    <= 1'b1;
                    SRAM_UB    <= 1'b1;
                    SRAM_OE    <= 1'b1;
                    SRAM_WE    <= 1'b1;
                    SRAM_DQ_OE <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: three arbiters (ACCESS_CYCLES = 2, 1, 15) on behavioural
// SRAM models. Expected read data comes from a transaction-level memory map,
// expected grant order and ACK timing from the round-robin rule and the
// access length, expected strobe widths from ACCESS_CYCLES.
module tb_sram_arbiter;

    localparam int N_DUT = 3;
    localparam int DEPTH = 262144;

    logic clk;
    logic rst_n;

    logic [N_DUT-1:0] f_req, f_ack, l_req, l_we, l_ack;
    logic [N_DUT-1:0] ce, oe, we, lb, ub, dq_oe;
    logic [17:0] f_addr [N_DUT];
    logic [17:0] l_addr [N_DUT];
    logic [17:0] sram_a [N_DUT];
    logic [15:0] l_wdata [N_DUT];
    logic [15:0] f_rdata [N_DUT];
    logic [15:0] l_rdata [N_DUT];
    logic [15:0] dq_out [N_DUT];
    logic [15:0] sram_d [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        sram_arbiter #(
            .ACCESS_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .CLK        (clk),
            .RESET_N    (rst_n),
            .F_REQ      (f_req[g]),
            .F_ADDR     (f_addr[g]),
            .F_ACK      (f_ack[g]),
            .F_RDATA    (f_rdata[g]),
            .L_REQ      (l_req[g]),
            .L_WE       (l_we[g]),
            .L_ADDR     (l_addr[g]),
            .L_WDATA    (l_wdata[g]),
            .L_ACK      (l_ack[g]),
            .L_RDATA    (l_rdata[g]),
            .SRAM_CE    (ce[g]),
            .SRAM_OE    (oe[g]),
            .SRAM_WE    (we[g]),
            .SRAM_LB    (lb[g]),
            .SRAM_UB    (ub[g]),
            .SRAM_A     (sram_a[g]),
            .SRAM_DQ_OUT(dq_out[g]),
            .SRAM_DQ_OE (dq_oe[g]),
            .SRAM_D     (sram_d[g])
        );
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int acc_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Power-up contents of every SRAM model.
    function automatic logic [15:0] init_val(input int k, input logic [17:0] a);
        logic [31:0] v;
        if (a == 18'h00010) return 16'h8A25;
        v = {14'd0, a} * 32'd7;
        return v[15:0] ^ 16'h5A3C ^ 16'(k);
    endfunction

    // ---------------- behavioural SRAM pins + protocol monitor ----------------
    logic [15:0] mem [N_DUT][DEPTH];
    bit          mem_ready = 1'b0;
    bit          pend [N_DUT];
    logic [17:0] pend_a [N_DUT];
    logic [15:0] pend_d [N_DUT];
    int oe_run [N_DUT], we_run [N_DUT], dqoe_run [N_DUT];
    int oe_w [N_DUT], we_w [N_DUT], dqoe_w [N_DUT];
    int oe_n [N_DUT], we_n [N_DUT], dqoe_n [N_DUT];
    int f_ack_cnt [N_DUT], l_ack_cnt [N_DUT];
    bit prev_we_low [N_DUT];
    logic [17:0] prev_a [N_DUT];
    int viol = 0;

    always_comb begin
        for (int k = 0; k < N_DUT; k++) begin
            sram_d[k] = (!ce[k] && !oe[k]) ? mem[k][sram_a[k]] : 16'h0BAD;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!mem_ready) begin
                for (int k = 0; k < N_DUT; k++)
                    for (int a = 0; a < DEPTH; a++)
                        mem[k][a] = init_val(k, 18'(a));
                mem_ready = 1'b1;
            end
            for (int k = 0; k < N_DUT; k++) begin
                if (!oe[k]) oe_run[k]++;
                else if (oe_run[k] != 0) begin oe_w[k] = oe_run[k]; oe_n[k]++; oe_run[k] = 0; end
                if (!we[k]) we_run[k]++;
                else if (we_run[k] != 0) begin we_w[k] = we_run[k]; we_n[k]++; we_run[k] = 0; end
                if (dq_oe[k]) dqoe_run[k]++;
                else if (dqoe_run[k] != 0) begin dqoe_w[k] = dqoe_run[k]; dqoe_n[k]++; dqoe_run[k] = 0; end
                if (!oe[k] && dq_oe[k]) viol++;
                if (!we[k] && (!dq_oe[k] || ce[k])) viol++;
                if (!we[k] && prev_we_low[k] && sram_a[k] != prev_a[k]) viol++;
                if (f_ack[k] && l_ack[k]) viol++;
                prev_we_low[k] = !we[k];
                prev_a[k]      = sram_a[k];
                if (f_ack[k]) f_ack_cnt[k]++;
                if (l_ack[k]) l_ack_cnt[k]++;
                // A write lands only when WE rises while the chip stays selected.
                if (!ce[k] && !we[k] && dq_oe[k]) begin
                    pend[k] = 1'b1; pend_a[k] = sram_a[k]; pend_d[k] = dq_out[k];
                end else if (pend[k] && !ce[k]) begin
                    mem[k][pend_a[k]] = pend_d[k]; pend[k] = 1'b0;
                end else if (ce[k]) begin
                    pend[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- transaction-level reference ----------------
    logic [15:0] ref_mem [int];
    bit          last_served [N_DUT];   // 1 = port L served last
    logic [15:0] last_f [N_DUT];
    logic [15:0] last_l [N_DUT];

    function automatic int key(input int k, input logic [17:0] a);
        return k * DEPTH + int'(a);
    endfunction

    function automatic logic [15:0] ref_read(input int k, input logic [17:0] a);
        if (ref_mem.exists(key(k, a))) return ref_mem[key(k, a)];
        return init_val(k, a);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < N_DUT; k++) begin
            last_served[k] = 1'b1;
            last_f[k] = 16'd0;
            last_l[k] = 16'd0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called in the ACK cycle: checks read data and the other port's hold.
    task automatic finish_txn(input int k, input bit is_l, input bit wr,
                              input logic [17:0] addr, input logic [15:0] wd);
        logic [15:0] exp;
        last_served[k] = is_l;
        if (wr) begin
            ref_mem[key(k, addr)] = wd;
            check($sformatf("d%0d L_RDATA hold on write", k), 32'(l_rdata[k]), 32'(last_l[k]));
            check($sformatf("d%0d F_RDATA hold on L write", k), 32'(f_rdata[k]), 32'(last_f[k]));
        end else begin
            exp = ref_read(k, addr);
            if (is_l) begin
                check($sformatf("d%0d L_RDATA @%05h", k, addr), 32'(l_rdata[k]), 32'(exp));
                last_l[k] = exp;
                check($sformatf("d%0d F_RDATA hold", k), 32'(f_rdata[k]), 32'(last_f[k]));
            end else begin
                check($sformatf("d%0d F_RDATA @%05h", k, addr), 32'(f_rdata[k]), 32'(exp));
                last_f[k] = exp;
                check($sformatf("d%0d L_RDATA hold", k), 32'(l_rdata[k]), 32'(last_l[k]));
            end
        end
    endtask

    // Single access on an idle arbiter: latency, data, strobe widths.
    task automatic do_access(input int k, input bit is_l, input bit wr,
                             input logic [17:0] addr, input logic [15:0] wd);
        int acc = acc_of(k);
        int n = 0;
        bit got = 1'b0;
        int oe0 = oe_n[k], we0 = we_n[k], dq0 = dqoe_n[k];
        int a0 = is_l ? l_ack_cnt[k] : f_ack_cnt[k];
        if (is_l) begin
            l_req[k] = 1'b1; l_we[k] = wr; l_addr[k] = addr; l_wdata[k] = wd;
        end else begin
            f_req[k] = 1'b1; f_addr[k] = addr;
        end
        while (!got && n < 40) begin
            tick();
            n++;
            got = is_l ? l_ack[k] : f_ack[k];
        end
        f_req[k] = 1'b0;
        l_req[k] = 1'b0;
        check($sformatf("d%0d %s latency", k, is_l ? "L" : "F"), 32'(n), 32'(acc + 2));
        if (got) finish_txn(k, is_l, wr, addr, wd);
        tick();
        tick();
        check($sformatf("d%0d single ACK pulse", k),
              32'((is_l ? l_ack_cnt[k] : f_ack_cnt[k]) - a0), 32'd1);
        if (wr) begin
            check($sformatf("d%0d WE pulses", k), 32'(we_n[k] - we0), 32'd1);
            check($sformatf("d%0d WE width", k), 32'(we_w[k]), 32'(acc));
            check($sformatf("d%0d DQ_OE width", k), 32'(dqoe_w[k]), 32'(acc + 2));
            check($sformatf("d%0d OE idle on write", k), 32'(oe_n[k] - oe0), 32'd0);
            check($sformatf("d%0d SRAM word @%05h", k, addr), 32'(mem[k][addr]), 32'(wd));
        end else begin
            check($sformatf("d%0d OE pulses", k), 32'(oe_n[k] - oe0), 32'd1);
            check($sformatf("d%0d OE width", k), 32'(oe_w[k]), 32'(acc + 1));
            check($sformatf("d%0d WE/DQ idle on read", k), 32'((we_n[k] - we0) + (dqoe_n[k] - dq0)), 32'd0);
        end
    endtask

    // Both ports request in the same cycle; the winner follows round-robin.
    task automatic do_pair(input int k, input bit l_wr, input logic [17:0] fa,
                           input logic [17:0] la, input logic [15:0] wd);
        int acc = acc_of(k);
        bit exp_l = ~last_served[k];
        f_req[k] = 1'b1; f_addr[k] = fa;
        l_req[k] = 1'b1; l_we[k] = l_wr; l_addr[k] = la; l_wdata[k] = wd;
        for (int i = 0; i < 2; i++) begin
            int n = 0;
            bit got = 1'b0;
            while (!got && n < 40) begin
                tick();
                n++;
                got = f_ack[k] | l_ack[k];
            end
            check($sformatf("d%0d pair#%0d spacing", k, i), 32'(n), 32'(i == 0 ? acc + 2 : acc + 3));
            if (got) begin
                check($sformatf("d%0d pair#%0d port", k, i), 32'(l_ack[k]), 32'(exp_l));
                finish_txn(k, l_ack[k], l_ack[k] & l_wr, l_ack[k] ? la : fa, wd);
                if (l_ack[k]) l_req[k] = 1'b0; else f_req[k] = 1'b0;
            end
            exp_l = ~exp_l;
        end
        f_req[k] = 1'b0;
        l_req[k] = 1'b0;
        tick();
    endtask

    // Both ports held high for nacc accesses: strict alternation.
    task automatic saturate(input int k, input int nacc);
        int acc = acc_of(k);
        int t = 0, last_t = 0, got = 0;
        int fa0, la0;
        bit exp_l = ~last_served[k];
        f_req[k] = 1'b1; f_addr[k] = 18'h00010;
        l_req[k] = 1'b1; l_we[k] = 1'b0; l_addr[k] = 18'h3FFFF;
        while (got < nacc && t < nacc * (acc + 3) + 20) begin
            tick();
            t++;
            if (f_ack[k] || l_ack[k]) begin
                check($sformatf("sat ack#%0d port", got), 32'(l_ack[k]), 32'(exp_l));
                check($sformatf("sat ack#%0d spacing", got), 32'(t - last_t),
                      32'(got == 0 ? acc + 2 : acc + 3));
                finish_txn(k, l_ack[k], 1'b0, l_ack[k] ? 18'h3FFFF : 18'h00010, 16'd0);
                exp_l = ~exp_l;
                last_t = t;
                got++;
                if (got == nacc) begin
                    f_req[k] = 1'b0;
                    l_req[k] = 1'b0;
                end
            end
        end
        check("sat ack count", 32'(got), 32'(nacc));
        f_req[k] = 1'b0;
        l_req[k] = 1'b0;
        fa0 = f_ack_cnt[k];
        la0 = l_ack_cnt[k];
        repeat (8) tick();
        check("sat no extra grant", 32'((f_ack_cnt[k] - fa0) + (l_ack_cnt[k] - la0)), 32'd0);
    endtask

    function automatic logic [17:0] pool_addr(input int i);
        case (i)
            0:       return 18'h00000;
            1:       return 18'h3FFFF;
            2:       return 18'h00010;
            3:       return 18'h12345;
            4:       return 18'h20000;
            5:       return 18'h1FFFF;
            6:       return 18'h00001;
            default: return 18'h2AAAA;
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int fa0;
        int la0;
        f_req = '0; l_req = '0; l_we = '0;
        for (int k = 0; k < N_DUT; k++) begin
            f_addr[k] = '0; l_addr[k] = '0; l_wdata[k] = '0;
        end
        reset_model();
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("reset strobes", 32'({ce[0], oe[0], we[0], lb[0], ub[0], dq_oe[0]}), 32'b111110);
        check("reset SRAM_A", 32'(sram_a[0]), 32'd0);
        check("reset DQ_OUT", 32'(dq_out[0]), 32'd0);
        check("reset ACKs", 32'({f_ack, l_ack}), 32'd0);
        check("reset RDATA", 32'({f_rdata[0], l_rdata[0]}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch of the preloaded word
        do_access(0, 1'b0, 1'b0, 18'h00010, 16'h0000);

        // Loader write then read-back at the top address
        do_access(0, 1'b1, 1'b1, 18'h3FFFF, 16'h1060);
        do_access(0, 1'b1, 1'b0, 18'h3FFFF, 16'h0000);

        // Simultaneous requests straight out of reset, held for 8 accesses
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        reset_model();
        tick();
        saturate(0, 8);

        // Request-field hijack: address changes and REQ drops after grant
        fa0 = f_ack_cnt[0];
        f_req[0] = 1'b1; f_addr[0] = 18'h12345;
        begin
            int n = 1;
            bit got = 1'b0;
            tick();
            f_addr[0] = 18'h2AAAA;
            f_req[0] = 1'b0;
            while (!got && n < 40) begin
                tick();
                n++;
                got = f_ack[0];
            end
            check("hijack latency", 32'(n), 32'(acc_of(0) + 2));
            check("hijack SRAM_A", 32'(sram_a[0]), 32'h12345);
            if (got) finish_txn(0, 1'b0, 1'b0, 18'h12345, 16'h0000);
        end
        repeat (10) tick();
        check("hijack one ACK only", 32'(f_ack_cnt[0] - fa0), 32'd1);

        // Reset during the ACCESS phase of a loader write
        la0 = l_ack_cnt[0];
        l_req[0] = 1'b1; l_we[0] = 1'b1; l_addr[0] = 18'h20000; l_wdata[0] = 16'hC0DE;
        tick();                 // SETUP
        tick();                 // first ACCESS cycle, WE low
        check("mid-write WE low", 32'(we[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort strobes", 32'({ce[0], oe[0], we[0], lb[0], ub[0], dq_oe[0]}), 32'b111110);
        l_req[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        reset_model();
        repeat (8) tick();
        check("abort no L_ACK", 32'(l_ack_cnt[0] - la0), 32'd0);
        do_access(0, 1'b0, 1'b0, 18'h20000, 16'h0000);

        // Parameter sweep: ACCESS_CYCLES = 1 and 15
        for (int k = 1; k < N_DUT; k++) begin
            do_access(k, 1'b0, 1'b0, 18'h00010, 16'h0000);
            do_access(k, 1'b1, 1'b1, 18'h3FFFF, 16'(16'hBEE0 + k));
            do_access(k, 1'b1, 1'b0, 18'h3FFFF, 16'h0000);
            do_access(k, 1'b0, 1'b0, 18'h3FFFF, 16'h0000);
        end

        // Randomised traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            int          kind = int'($urandom_range(0, 3));
            logic [17:0] a1   = pool_addr(int'($urandom_range(0, 7)));
            logic [17:0] a2   = pool_addr(int'($urandom_range(0, 7)));
            logic [15:0] wd   = 16'($urandom);
            case (kind)
                0:       do_access(0, 1'b0, 1'b0, a1, wd);
                1:       do_access(0, 1'b1, 1'b0, a1, wd);
                2:       do_access(0, 1'b1, 1'b1, a1, wd);
                default: do_pair(0, 1'($urandom_range(0, 1)), a1, a2, wd);
            endcase
        end

        check("protocol invariants", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
